sd_sector_buffer: RTL
=====================

// Module: sd_sector_buffer
// PURPOSE
//  Bridge between the CPU bus decode and sd_controller for single-sector reads.
//  - Latches the sector address and runs the rd handshake with sd_controller.
//  - Captures exactly one 512-byte sector into a block-RAM buffer.
//  - Exposes the buffer to the bus as byte-addressed read data, with avail, busy and err flags.
// PARAMETERS
//  SECTOR_BYTES    512       bytes captured per read; index width = $clog2(SECTOR_BYTES)
//  IDLE_STATUS     5'd6      sd_status code meaning controller idle / waiting for rd
//  TIMEOUT_CYCLES  24'd5000000  max cycles without progress in any non-IDLE state (100 ms @ 50 MHz)
// PORTS
//  clk               in   1   system clock (CLOCK_50)
//  reset_n           in   1   asynchronous active-low reset (KEY0)
//  addr_we           in   1   bus write strobe to Sdc_addr register
//  addr_wdata        in   32  sector address written by bus
//  rd_req            in   1   bus write strobe to Sdc_read (start read), level or pulse
//  rd_index          in   9   byte offset into buffer (bus_address - Sdc_base)
//  rd_data           out  8   buffer byte at rd_index, registered
//  avail             out  1   1 = buffer holds a complete sector from the last read
//  busy              out  1   1 = FSM not in IDLE
//  err               out  1   1 = last read aborted by timeout
//  sd_ready          in   1   sd_controller ready
//  sd_status         in   5   sd_controller state code
//  sd_byte_available in   1   sd_controller byte strobe (level, may last many cycles)
//  sd_dout           in   8   sd_controller data byte
//  sd_rd             out  1   rd request to sd_controller
//  sd_address        out  32  sector address to sd_controller
// BEHAVIOUR
//  Reset values
//  - rd_data=0, avail=0, busy=0, err=0, sd_rd=0, sd_address=0.
//  - FSM=IDLE; index, timeout counter and edge register cleared.
//  - Buffer RAM contents are NOT cleared.
//  Address register
//  - addr_we in IDLE loads sd_address.
//  - addr_we while busy is ignored; sd_address stays stable for the whole read.
//  Read port
//  - rd_data <= buf[rd_index] every cycle; 1-cycle latency; valid in any state.
//  - A read during capture returns whatever byte is currently stored there.
//  FSM
//  - IDLE:  rd_req=1 -> WAIT_RDY; same edge: avail<=0, err<=0, index<=0.
//           rd_req in any other state is ignored.
//  - WAIT_RDY: sd_ready=1 -> ISSUE; sd_rd<=1.
//  - ISSUE: hold sd_rd=1 until sd_status!=IDLE_STATUS, then sd_rd<=0 -> CAPTURE.
//  - CAPTURE: on each rising edge of sd_byte_available (level & ~registered level):
//      buf[index]<=sd_dout; index++.
//      Write of index SECTOR_BYTES-1 -> DRAIN.
//  - DRAIN: sd_ready=1 -> IDLE, avail<=1 (earliest 1 cycle after last byte write).
//  Edge detection
//  - The sd_byte_available registered copy updates every cycle in every state.
//  - A level already high on entry to CAPTURE is not counted.
//  - Bytes arriving outside CAPTURE are discarded, never written.
//  Timeout
//  - Counter cleared on entering WAIT_RDY and on every captured byte.
//  - Increments in WAIT_RDY, ISSUE, CAPTURE and DRAIN.
//  - Reaching TIMEOUT_CYCLES -> IDLE, sd_rd<=0, err<=1, avail stays 0.
//  Simultaneous events
//  - addr_we and rd_req in the same IDLE cycle: the new address is used.
//  Reset mid-read
//  - Immediate return to reset values; sd_rd drops asynchronously.
//  - Partial buffer data remains in RAM but avail=0.
// TESTING
//  1. Write addr 0x20, pulse rd_req; model ready, status 6->2, 512 strobes of bytes i&0xFF
//     -> sd_address=0x20; sd_rd high until status!=6; avail=1 after ready;
//     rd_index=0/255/511 -> 00/FF/FF one cycle later.
//  2. sd_byte_available held high 40 cycles per byte -> exactly one write per strobe;
//     index ends at 512; no duplicates.
//  3. Model stops after 100 bytes -> err=1, avail=0, busy=0 at TIMEOUT_CYCLES (set to 1000)
//     after the last byte.
//  4. rd_req and addr_we (0x99) pulsed mid-CAPTURE -> ignored; sd_address stays 0x20;
//     read completes normally.
//  5. reset_n low at byte 300 -> all outputs 0 within the reset; new read after release
//     fills the buffer from index 0.
//  6. Second read after a completed one -> avail drops on the rd_req cycle and rises again
//     with the new sector's data.

Source files
------------

// File: rtl/sd_sector_buffer.sv
// Single-sector read bridge between the CPU bus and sd_controller: latches the sector
// address, runs the rd handshake, captures one sector into block RAM and serves it byte-wise.
module sd_sector_buffer #(
    parameter int          SECTOR_BYTES   = 512,
    parameter logic [4:0]  IDLE_STATUS    = 5'd6,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000,
    localparam int         IDX_W          = $clog2(SECTOR_BYTES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             addr_we,
    input  logic [31:0]      addr_wdata,
    input  logic             rd_req,
    input  logic [IDX_W-1:0] rd_index,
    output logic [7:0]       rd_data,
    output logic             avail,
    output logic             busy,
    output logic             err,
    input  logic             sd_ready,
    input  logic [4:0]       sd_status,
    input  logic             sd_byte_available,
    input  logic [7:0]       sd_dout,
    output logic             sd_rd,
    output logic [31:0]      sd_address
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_RDY, S_ISSUE, S_CAPTURE, S_DRAIN} state_t;

    localparam logic [IDX_W:0] LAST_IDX = (IDX_W + 1)'(SECTOR_BYTES - 1);
    localparam logic [23:0]    TMO_LAST = TIMEOUT_CYCLES - 24'd1;

    state_t         r_state;
    state_t         w_next;
    logic [IDX_W:0] r_idx;
    logic [23:0]    r_tmo;
    logic           r_bav_q;
    logic           r_sd_rd;
    logic           r_avail;
    logic           r_err;
    logic [31:0]    r_sd_addr;
    logic [7:0]     r_rd_data;
    logic [7:0]     r_buf [SECTOR_BYTES];

    logic w_byte_edge;
    logic w_tmo_hit;
    logic w_start;
    logic w_issue;
    logic w_issued;
    logic w_cap;
    logic w_done;
    logic w_tmo;

    // A strobe level already high when CAPTURE is entered never produces an edge here.
    assign w_byte_edge = sd_byte_available & ~r_bav_q;
    assign w_tmo_hit   = (r_tmo == TMO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_issue  = 1'b0;
        w_issued = 1'b0;
        w_cap    = 1'b0;
        w_done   = 1'b0;
        w_tmo    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (rd_req) begin
                    w_next  = S_WAIT_RDY;
                    w_start = 1'b1;
                end
            end
            S_WAIT_RDY: begin
                if (sd_ready) begin
                    w_next  = S_ISSUE;
                    w_issue = 1'b1;
                end else if (w_tmo_hit) begin
                    w_tmo = 1'b1;
                end
            end
            S_ISSUE: begin
                if (sd_status != IDLE_STATUS) begin
                    w_next   = S_CAPTURE;
                    w_issued = 1'b1;
                end else if (w_tmo_hit) begin
                    w_tmo = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (w_byte_edge) begin
                    w_cap = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_next = S_DRAIN;
                    end
                end else if (w_tmo_hit) begin
                    w_tmo = 1'b1;
                end
            end
            S_DRAIN: begin
                if (sd_ready) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end else if (w_tmo_hit) begin
                    w_tmo = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (w_tmo) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bav_q   <= 1'b0;
            r_sd_addr <= '0;
            r_sd_rd   <= 1'b0;
            r_avail   <= 1'b0;
            r_err     <= 1'b0;
            r_idx     <= '0;
            r_tmo     <= '0;
        end else begin
            r_bav_q <= sd_byte_available;
            if (r_state == S_IDLE && addr_we) begin
                r_sd_addr <= addr_wdata;
            end
            if (w_start) begin
                r_avail <= 1'b0;
                r_err   <= 1'b0;
                r_idx   <= '0;
            end
            if (w_issue) begin
                r_sd_rd <= 1'b1;
            end
            if (w_issued || w_tmo) begin
                r_sd_rd <= 1'b0;
            end
            if (w_cap) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_done) begin
                r_avail <= 1'b1;
            end
            if (w_tmo) begin
                r_err <= 1'b1;
            end
            // Any sign of progress restarts the watchdog.
            if (w_start || w_cap || w_tmo) begin
                r_tmo <= '0;
            end else if (r_state != S_IDLE) begin
                r_tmo <= r_tmo + 24'd1;
            end
        end
    end

    // Buffer storage is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_cap) begin
            r_buf[r_idx[IDX_W-1:0]] <= sd_dout;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_buf[rd_index];
        end
    end

    assign rd_data    = r_rd_data;
    assign avail      = r_avail;
    assign busy       = (r_state != S_IDLE);
    assign err        = r_err;
    assign sd_rd      = r_sd_rd;
    assign sd_address = r_sd_addr;

endmodule
